// File: rtl/vector_register_file_grouped.sv
// Vector register file with LMUL-grouped, masked, vl-bounded streaming writes.
// Optional: define VRF_TAIL_AGNOSTIC_ONES_EN to fill tail elements with ones when wr_ta=1.
module vector_register_file_grouped #(
    parameter int VREG_BITS = 256,
    parameter int NUM_VREGS = 32,
    parameter int VL_WIDTH  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           rs3,
    output logic [VREG_BITS-1:0] rs1_data,
    output logic [VREG_BITS-1:0] rs2_data,
    output logic [VREG_BITS-1:0] rs3_data,
    output logic [VREG_BITS-1:0] v0_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [4:0]           wr_rd,
    input  logic [1:0]           wr_lmul,
    input  logic [1:0]           wr_sew,
    input  logic                 wr_vm,
    input  logic                 wr_ta,
    input  logic [VL_WIDTH-1:0]  wr_vl,
    input  logic [VREG_BITS-1:0] wr_data,
    output logic                 wr_done,
    output logic                 wr_error
);

    localparam int NB = VREG_BITS / 8;
    localparam int IW = $clog2(VREG_BITS);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t state, state_next;

    logic [VREG_BITS-1:0] vregs [NUM_VREGS];
    logic [4:0]           rs1_q, rs2_q, rs3_q;

    logic [4:0]           rd_q;
    logic [1:0]           lmul_q, sew_q;
    logic                 vm_q;
    logic [VL_WIDTH-1:0]  vl_q;
    logic [VREG_BITS-1:0] mask_q;
    logic                 err_q;
    logic [2:0]           beat_q;

    logic                 first_beat, accept, last_beat, illegal, skip;
    logic [4:0]           rd_eff, widx;
    logic [1:0]           lmul_eff, sew_eff;
    logic                 vm_eff, ta_eff;
    logic [VL_WIDTH-1:0]  vl_eff;
    logic [VREG_BITS-1:0] mask_eff;
    logic [2:0]           beat_eff;
    logic [3:0]           group_regs;
    logic [VREG_BITS-1:0] bit_en, new_data;
    logic [31:0]          gbyte, elem;
    logic                 in_body;

    // The first beat is written in the same cycle its header arrives, so header
    // fields come straight from the ports in IDLE and from the latches afterwards.
    assign first_beat = (state == IDLE);
    assign rd_eff     = first_beat ? wr_rd   : rd_q;
    assign lmul_eff   = first_beat ? wr_lmul : lmul_q;
    assign sew_eff    = first_beat ? wr_sew  : sew_q;
    assign vm_eff     = first_beat ? wr_vm   : vm_q;
    assign vl_eff     = first_beat ? wr_vl   : vl_q;
    assign mask_eff   = first_beat ? vregs[0] : mask_q;
    assign beat_eff   = first_beat ? 3'd0    : beat_q;

`ifdef VRF_TAIL_AGNOSTIC_ONES_EN
    logic ta_q;
    assign ta_eff = first_beat ? wr_ta : ta_q;
`else
    logic ta_unused;
    assign ta_unused = wr_ta;
    assign ta_eff    = 1'b0;
`endif

    assign group_regs = 4'd1 << lmul_eff;
    assign last_beat  = ({1'b0, beat_eff} == (group_regs - 4'd1));
    assign illegal    = ((rd_eff[2:0] & 3'(group_regs - 4'd1)) != 3'd0) ||
                        ((rd_eff == 5'd0) && !vm_eff);
    assign skip       = illegal || (vl_eff == '0);
    assign widx       = rd_eff + {2'b00, beat_eff};

    assign wr_ready = rdy_in && (state != DONE);
    assign accept   = wr_valid && wr_ready;
    assign wr_done  = rdy_in && (state == DONE);
    assign wr_error = wr_done && err_q;

    assign rs1_data = vregs[rs1_q];
    assign rs2_data = vregs[rs2_q];
    assign rs3_data = vregs[rs3_q];
    assign v0_data  = vregs[0];

    // Byte-granular write enables: every byte of an element shares the element's
    // global index (beat*NB + byte) >> sew, since NB is a multiple of element size.
    always_comb begin
        bit_en   = '0;
        new_data = wr_data;
        gbyte    = '0;
        elem     = '0;
        in_body  = 1'b0;
        for (int b = 0; b < NB; b++) begin
            gbyte   = 32'(beat_eff) * 32'(NB) + 32'(b);
            elem    = gbyte >> sew_eff;
            in_body = elem < 32'(vl_eff);
            if (in_body && (vm_eff || mask_eff[elem[IW-1:0]])) begin
                bit_en[b*8 +: 8] = 8'hFF;
            end else if (!in_body && ta_eff) begin
                bit_en[b*8 +: 8]   = 8'hFF;
                new_data[b*8 +: 8] = 8'hFF;
            end
        end
        if (skip) begin
            bit_en = '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (lmul_eff != 2'd0) ? WRITE : DONE;
            WRITE:   if (accept && last_beat) state_next = DONE;
            DONE:    if (rdy_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // Header and v0 mask are captured once per group; beat counts the next beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= '0;
            lmul_q <= '0;
            sew_q  <= '0;
            vm_q   <= 1'b0;
            vl_q   <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
            beat_q <= '0;
`ifdef VRF_TAIL_AGNOSTIC_ONES_EN
            ta_q   <= 1'b0;
`endif
        end else if (accept) begin
            if (first_beat) begin
                rd_q   <= wr_rd;
                lmul_q <= wr_lmul;
                sew_q  <= wr_sew;
                vm_q   <= wr_vm;
                vl_q   <= wr_vl;
                mask_q <= vregs[0];
                err_q  <= illegal;
                beat_q <= 3'd1;
`ifdef VRF_TAIL_AGNOSTIC_ONES_EN
                ta_q   <= wr_ta;
`endif
            end else begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                vregs[i] <= '0;
            end
            rs1_q <= '0;
            rs2_q <= '0;
            rs3_q <= '0;
        end else if (rdy_in) begin
            rs1_q <= rs1;
            rs2_q <= rs2;
            rs3_q <= rs3;
            if (accept) begin
                vregs[widx] <= (vregs[widx] & ~bit_en) | (new_data & bit_en);
            end
        end
    end

endmodule
